apb_master_bridge: RTL and testbench



---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_timeout_cnt.sv | 41 ++++
 rtl/apb_master_bridge.sv | 156 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared widths and FSM state type for the APB master bridge
//
// Purpose: default bus widths and the bridge state enumeration, imported by
// every file of the bridge. No ports.

package apb_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS-phase wait counter with abort flag
//
// Purpose: counts ACCESS cycles spent with PREADY low and flags the cycle
// whose increment would reach LIMIT. LIMIT = 0 disables the abort.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clr         restart the count (asserted when entering ACCESS)
//   inc         one more wait cycle observed this cycle
//   expired     this wait cycle is the LIMIT-th one; abort the transfer

module apb_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Combinational so the bridge can leave ACCESS on the same edge the
  // count reaches LIMIT; PREADY has priority because inc is only asserted
  // while PREADY is low.
  assign expired = (LIMIT > 0) && inc && (cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command stream to APB requester
//
// Purpose: issues one APB SETUP/ACCESS transfer per accepted command and
// returns read data or a timeout flag on the response stream. All outputs
// are registered; one transfer outstanding at a time.
// Ports:
//   PCLK, PRESET_N                  clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata command stream in
//   rsp_valid/ready/rdata/timeout   response stream out
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE APB request outputs
//   PRDATA/PREADY                   APB completer inputs

module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET_N,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  apb_state_e            state, state_n;
  logic                  cmd_ready_n, rsp_valid_n, rsp_timeout_n;
  logic                  pwrite_n, psel_n, penable_n;
  logic [DATA_WIDTH-1:0] rsp_rdata_n, pwdata_n;
  logic [ADDR_WIDTH-1:0] paddr_n;
  logic                  tmo_clr, tmo_inc, tmo_expired;

  apb_timeout_cnt #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (PCLK),
    .rst_n  (PRESET_N),
    .clr    (tmo_clr),
    .inc    (tmo_inc),
    .expired(tmo_expired)
  );

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_ready   <= cmd_ready_n;
      rsp_valid   <= rsp_valid_n;
      rsp_rdata   <= rsp_rdata_n;
      rsp_timeout <= rsp_timeout_n;
      PADDR       <= paddr_n;
      PWDATA      <= pwdata_n;
      PWRITE      <= pwrite_n;
      PSEL        <= psel_n;
      PENABLE     <= penable_n;
    end
  end

  // Computes the next value of every registered output; anything not
  // touched below holds, which keeps PADDR/PWRITE/PWDATA at their last
  // values through IDLE and RESP.
  always_comb begin
    state_n       = state;
    cmd_ready_n   = cmd_ready;
    rsp_valid_n   = rsp_valid;
    rsp_rdata_n   = rsp_rdata;
    rsp_timeout_n = rsp_timeout;
    paddr_n       = PADDR;
    pwdata_n      = PWDATA;
    pwrite_n      = PWRITE;
    psel_n        = PSEL;
    penable_n     = PENABLE;
    tmo_clr       = 1'b0;
    tmo_inc       = 1'b0;

    case (state)
      IDLE: begin
        // cmd_ready is a register, so it first rises one cycle after reset.
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_n = 1'b0;
          paddr_n     = cmd_addr;
          pwrite_n    = cmd_write;
          pwdata_n    = cmd_write ? cmd_wdata : '0;
          psel_n      = 1'b1;
          penable_n   = 1'b0;
          state_n     = SETUP;
        end
      end

      SETUP: begin
        penable_n = 1'b1;
        tmo_clr   = 1'b1;
        state_n   = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          rsp_rdata_n   = PWRITE ? '0 : PRDATA;
          rsp_timeout_n = 1'b0;
          rsp_valid_n   = 1'b1;
          psel_n        = 1'b0;
          penable_n     = 1'b0;
          state_n       = RESP;
        end else begin
          tmo_inc = 1'b1;
          if (tmo_expired) begin
            // Deliberately drops PSEL without PREADY so a dead completer
            // cannot stall the requester forever.
            rsp_rdata_n   = '0;
            rsp_timeout_n = 1'b1;
            rsp_valid_n   = 1'b1;
            psel_n        = 1'b0;
            penable_n     = 1'b0;
            state_n       = RESP;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          cmd_ready_n = 1'b1;
          state_n     = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge

module tb_apb_master_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET_N = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  apb_master_bridge #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK       (PCLK),
    .PRESET_N   (PRESET_N),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PWRITE     (PWRITE),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prd;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_to;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Reference: accept at N, SETUP at N+1, ACCESS from N+2. A transfer
  // finishes after waits+1 ACCESS cycles unless waits reaches TMO, in which
  // case it is aborted after TMO ACCESS cycles.
  function automatic void model(input logic wr, input int waits, input logic [31:0] prd,
                                output logic [31:0] rd, output logic to, output int lat);
    to  = (waits >= TMO);
    rd  = (wr || to) ? 32'h0 : prd;
    lat = to ? 2 + TMO : 3 + waits;
  endfunction

  // Runs one transfer; the completer holds PREADY low for `waits` ACCESS
  // cycles. cmd_valid stays high (with scrambled payload) until the response
  // is consumed, and the response is back-pressured for `hold` cycles.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] prd, input int hold,
                         output logic [31:0] rd, output logic to, output int lat);
    int   cyc;
    int   acc;
    int   cur;
    bit   got;
    logic [31:0] exp_pwdata;
    rd = '0;
    to = 1'b0;
    lat = -1;
    exp_pwdata = wr ? wdata : 32'h0;
    cyc = 0;
    while (!cmd_ready && cyc < 10) begin
      tick();
      cyc++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_wait", 64'd0, 64'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tick();
    check("setup_phase", {62'd0, PSEL, PENABLE}, 64'b10);
    check("setup_paddr", PADDR, addr);
    check("setup_pwrite", PWRITE, wr);
    check("setup_pwdata", PWDATA, exp_pwdata);
    check("setup_cmd_ready", cmd_ready, 1'b0);
    cmd_write = ~wr;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    acc = 0;
    got = 0;
    cur = 1;
    while (!got && cur < 25) begin
      if (PSEL && PENABLE) begin
        PREADY = (acc >= waits);
        PRDATA = PREADY ? prd : $urandom;
        acc++;
      end else begin
        PREADY = 1'($urandom);
        PRDATA = $urandom;
      end
      tick();
      cur++;
      PREADY = 1'b0;
      if (rsp_valid) begin
        got = 1;
      end else if (PSEL) begin
        check("access_penable", PENABLE, 1'b1);
        check("access_paddr", PADDR, addr);
        check("access_pwdata", PWDATA, exp_pwdata);
        check("access_pwrite", PWRITE, wr);
      end
    end
    if (!got) begin
      check("rsp_valid_wait", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    lat = cur;
    rd  = rsp_rdata;
    to  = rsp_timeout;
    check("resp_bus_idle", {62'd0, PSEL, PENABLE}, 64'b00);
    check("resp_cmd_ready", cmd_ready, 1'b0);
    check("resp_paddr_kept", PADDR, addr);
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_rsp_rdata", rsp_rdata, rd);
      check("hold_rsp_timeout", rsp_timeout, to);
      check("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    tick();
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 1'b0);
    check("post_cmd_ready", cmd_ready, 1'b1);
  endtask

  task automatic run_and_compare(input string tag, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int waits, input logic [31:0] prd,
                                 input int hold, input logic [31:0] e_rd, input logic e_to,
                                 input int e_lat);
    logic [31:0] rd;
    logic        to;
    int          lat;
    do_xfer(wr, addr, wdata, waits, prd, hold, rd, to, lat);
    check({tag, "_rdata"}, rd, e_rd);
    check({tag, "_timeout"}, to, e_to);
    check({tag, "_latency"}, lat, e_lat);
  endtask

  vec_t vecs[6];
  int   setups[$];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h5A5A_5A5A, 0, 32'h0,         1'b0, 3};
    vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         3, 32'h1234_5678, 5, 32'h1234_5678, 1'b0, 6};
    vecs[2] = '{1'b0, 32'h0000_0030, 32'h0,         9, 32'h8765_4321, 1, 32'h0,         1'b1, 6};
    vecs[3] = '{1'b0, 32'h0000_0034, 32'h0,         3, 32'hAAAA_5555, 0, 32'hAAAA_5555, 1'b0, 6};
    vecs[4] = '{1'b1, 32'h0000_0044, 32'h0102_0304, 2, 32'hFFFF_FFFF, 2, 32'h0,         1'b0, 5};
    vecs[5] = '{1'b1, 32'h0000_0048, 32'h0BAD_F00D, 4, 32'h0000_0001, 0, 32'h0,         1'b1, 6};

    // Reset
    #2 PRESET_N = 1'b0;
    tick();
    tick();
    tick();
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_psel", PSEL, 1'b0);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_timeout", rsp_timeout, 1'b0);
    PRESET_N = 1'b1;
    check("release_cmd_ready_low", cmd_ready, 1'b0);
    tick();
    check("release_cmd_ready_high", cmd_ready, 1'b1);

    // Directed table
    for (int i = 0; i < 6; i++) begin
      run_and_compare($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                      vecs[i].waits, vecs[i].prd, vecs[i].hold,
                      vecs[i].exp_rdata, vecs[i].exp_to, vecs[i].exp_lat);
    end

    // Back-to-back issue with rsp_ready and PREADY held high
    PREADY    = 1'b1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0100;
    cmd_wdata = 32'h5555_AAAA;
    for (int c = 0; c < 11; c++) begin
      tick();
      if (PSEL && !PENABLE) setups.push_back(c);
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    check("interval_count_ok", setups.size() >= 2, 1'b1);
    if (setups.size() >= 2) check("issue_interval", setups[1] - setups[0], 4);
    check("interval_first_setup", setups.size() > 0 ? setups[0] : -1, 0);
    check("drain_cmd_ready", cmd_ready, 1'b1);

    // Reset during an ACCESS wait state
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0050;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_access", {62'd0, PSEL, PENABLE}, 64'b11);
    #2 PRESET_N = 1'b0;
    #1;
    check("async_psel", PSEL, 1'b0);
    check("async_penable", PENABLE, 1'b0);
    check("async_rsp_valid", rsp_valid, 1'b0);
    check("async_paddr", PADDR, 32'h0);
    tick();
    tick();
    PRESET_N = 1'b1;
    tick();
    check("rerelease_cmd_ready", cmd_ready, 1'b1);
    run_and_compare("after_reset", 1'b0, 32'h0000_0060, 32'h0, 1, 32'hCAFE_F00D, 0,
                    32'hCAFE_F00D, 1'b0, 4);

    // Randomized transfers against the reference model
    for (int t = 0; t < 40; t++) begin
      logic        wr;
      logic [31:0] addr, wdata, prd, e_rd;
      logic        e_to;
      int          waits, hold, e_lat;
      wr    = 1'($urandom);
      addr  = $urandom;
      wdata = $urandom;
      prd   = $urandom;
      waits = int'($urandom_range(0, 6));
      hold  = int'($urandom_range(0, 3));
      model(wr, waits, prd, e_rd, e_to, e_lat);
      run_and_compare($sformatf("rand%0d", t), wr, addr, wdata, waits, prd, hold,
                      e_rd, e_to, e_lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
